// File: rtl/alarm_scheduler.sv
// rtl/alarm_scheduler.sv - multi-slot BCD alarm scheduler with ring/snooze/timeout sequencing
// Snooze path (SNOOZE state, wake register, snooze_cnt) is built only when ALARM_SNOOZE_EN is defined.
module alarm_scheduler #(
  parameter int NUM_SLOTS  = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk_1s,
  input  logic                 reset,
  input  logic [1:0]           cur_h1,
  input  logic [3:0]           cur_h0,
  input  logic [3:0]           cur_m1,
  input  logic [3:0]           cur_m0,
  input  logic [3:0]           cur_s1,
  input  logic [3:0]           cur_s0,
  input  logic                 ld_slot,
  input  logic [SW-1:0]        ld_idx,
  input  logic [1:0]           ld_h1,
  input  logic [3:0]           ld_h0,
  input  logic [3:0]           ld_m1,
  input  logic [3:0]           ld_m0,
  input  logic                 ld_en,
  input  logic                 stop,
  input  logic                 snooze,
  output logic                 alarm,
  output logic [SW-1:0]        active_slot,
  output logic [NUM_SLOTS-1:0] pending,
  output logic [1:0]           snooze_cnt,
  output logic [1:0]           state
);

  localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RING   = 2'b01,
    S_SNOOZE = 2'b10
  } state_t;

  state_t st_q, st_d;

  logic [1:0]           sl_h1 [NUM_SLOTS];
  logic [3:0]           sl_h0 [NUM_SLOTS];
  logic [3:0]           sl_m1 [NUM_SLOTS];
  logic [3:0]           sl_m0 [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] sl_en;

  logic [NUM_SLOTS-1:0] match, pend_nx, pend_d;
  logic [SW-1:0]        low_idx, act_d;
  logic [RW-1:0]        ring_q, ring_d;
  logic                 sec_zero;

  assign sec_zero = (cur_s1 == 4'd0) && (cur_s0 == 4'd0);
  assign state    = st_q;

`ifdef ALARM_SNOOZE_EN
  localparam logic [1:0] SNZ_LIMIT = 2'(MAX_SNOOZE);
  logic [1:0]  cnt_q, cnt_d;
  logic [10:0] wake_q, wake_d, cur_mod, wake_sum;

  assign cur_mod    = ((11'(cur_h1) * 11'd10 + 11'(cur_h0)) * 11'd60)
                    + 11'(cur_m1) * 11'd10 + 11'(cur_m0);
  assign wake_sum   = cur_mod + 11'(SNOOZE_MIN);
  assign snooze_cnt = cnt_q;
`else
  localparam int unused_cfg = SNOOZE_MIN + MAX_SNOOZE;
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snooze_cnt    = 2'b00;
`endif

  // Digit-wise compare: an out-of-range BCD slot can never equal a valid time.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      match[i] = sl_en[i] && (sl_h1[i] == cur_h1) && (sl_h0[i] == cur_h0) &&
                 (sl_m1[i] == cur_m1) && (sl_m0[i] == cur_m0) && sec_zero;
    end
  end

  always_comb begin
    pend_nx = pending | match;
    if (ld_slot && !ld_en) pend_nx[ld_idx] = 1'b0;
    low_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pend_nx[i]) low_idx = SW'(i);
    end
  end

  always_comb begin
    st_d   = st_q;
    act_d  = active_slot;
    ring_d = ring_q;
    pend_d = pend_nx;
`ifdef ALARM_SNOOZE_EN
    cnt_d  = cnt_q;
    wake_d = wake_q;
`endif
    case (st_q)
      S_IDLE: begin
        if (|pend_nx) begin
          st_d            = S_RING;
          act_d           = low_idx;
          pend_d[low_idx] = 1'b0;
          ring_d          = '0;
`ifdef ALARM_SNOOZE_EN
          cnt_d           = 2'd0;
`endif
        end
      end
      S_RING: begin
        // stop outranks snooze, which outranks the timeout
        if (stop) begin
          st_d = S_IDLE;
        end
`ifdef ALARM_SNOOZE_EN
        else if (snooze && (cnt_q < SNZ_LIMIT)) begin
          st_d   = S_SNOOZE;
          cnt_d  = cnt_q + 2'd1;
          wake_d = (wake_sum >= 11'd1440) ? (wake_sum - 11'd1440) : wake_sum;
        end
`endif
        else if (ring_q == RING_LAST) begin
          st_d = S_IDLE;
        end else begin
          ring_d = ring_q + RW'(1);
        end
      end
`ifdef ALARM_SNOOZE_EN
      S_SNOOZE: begin
        if (stop) begin
          st_d = S_IDLE;
        end else if ((cur_mod == wake_q) && sec_zero) begin
          st_d   = S_RING;
          ring_d = '0;
        end
      end
`endif
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      st_q        <= S_IDLE;
      alarm       <= 1'b0;
      active_slot <= '0;
      pending     <= '0;
      ring_q      <= '0;
      sl_en       <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sl_h1[i] <= '0;
        sl_h0[i] <= '0;
        sl_m1[i] <= '0;
        sl_m0[i] <= '0;
      end
`ifdef ALARM_SNOOZE_EN
      cnt_q       <= '0;
      wake_q      <= '0;
`endif
    end else begin
      st_q        <= st_d;
      alarm       <= (st_d == S_RING);
      active_slot <= act_d;
      pending     <= pend_d;
      ring_q      <= ring_d;
`ifdef ALARM_SNOOZE_EN
      cnt_q       <= cnt_d;
      wake_q      <= wake_d;
`endif
      if (ld_slot) begin
        sl_h1[ld_idx] <= ld_h1;
        sl_h0[ld_idx] <= ld_h0;
        sl_m1[ld_idx] <= ld_m1;
        sl_m0[ld_idx] <= ld_m0;
        sl_en[ld_idx] <= ld_en;
      end
    end
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb/tb_alarm_scheduler.sv - self-checking bench for alarm_scheduler
// Observed vector: {alarm, state, active_slot, pending, snooze_cnt}.
module tb_alarm_scheduler;
  logic       clk_1s = 1'b0;
  logic       reset;
  logic [1:0] cur_h1;
  logic [3:0] cur_h0, cur_m1, cur_m0, cur_s1, cur_s0;
  logic       ld_slot;
  logic [1:0] ld_idx;
  logic [1:0] ld_h1;
  logic [3:0] ld_h0, ld_m1, ld_m0;
  logic       ld_en, stop, snooze;
  logic       alarm;
  logic [1:0] active_slot;
  logic [3:0] pending;
  logic [1:0] snooze_cnt;
  logic [1:0] state;

  logic [10:0] obs, want;
  assign obs = {alarm, state, active_slot, pending, snooze_cnt};

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: slot times as digit tuples, everything else plain integers
  logic [13:0] m_slot [4];
  bit          m_en   [4];
  logic [3:0]  m_pend;
  int          m_state, m_act, m_ring, m_cnt, m_wake;

  alarm_scheduler dut (
    .clk_1s(clk_1s), .reset(reset),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .cur_s1(cur_s1), .cur_s0(cur_s0),
    .ld_slot(ld_slot), .ld_idx(ld_idx), .ld_h1(ld_h1), .ld_h0(ld_h0),
    .ld_m1(ld_m1), .ld_m0(ld_m0), .ld_en(ld_en),
    .stop(stop), .snooze(snooze),
    .alarm(alarm), .active_slot(active_slot), .pending(pending),
    .snooze_cnt(snooze_cnt), .state(state)
  );

  always #5 clk_1s = ~clk_1s;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_1s);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_h1 = 2'(h / 10); cur_h0 = 4'(h % 10);
    cur_m1 = 4'(m / 10); cur_m0 = 4'(m % 10);
    cur_s1 = 4'(s / 10); cur_s0 = 4'(s % 10);
  endtask

  task automatic load(input int idx, input int h, input int m, input bit en);
    ld_slot = 1'b1; ld_idx = 2'(idx); ld_en = en;
    ld_h1 = 2'(h / 10); ld_h0 = 4'(h % 10); ld_m1 = 4'(m / 10); ld_m0 = 4'(m % 10);
    tick();
    ld_slot = 1'b0; ld_en = 1'b0;
  endtask

  task automatic clear_slots();
    set_time(12, 34, 56);
    for (int i = 0; i < 4; i++) load(i, 0, 0, 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_slot[i] = '0; m_en[i] = 1'b0; end
    m_pend = '0; m_state = 0; m_act = 0; m_ring = 0; m_cnt = 0; m_wake = 0;
  endtask

  task automatic model_step();
    int curmin;
    bit sec0;
    logic [3:0] pn;
    int low;
    curmin = (cur_h1 * 10 + cur_h0) * 60 + cur_m1 * 10 + cur_m0;
    sec0 = (cur_s1 == 0) && (cur_s0 == 0);
    pn = m_pend;
    for (int i = 0; i < 4; i++)
      if (m_en[i] && m_slot[i] == {cur_h1, cur_h0, cur_m1, cur_m0} && sec0) pn[i] = 1'b1;
    if (ld_slot && !ld_en) pn[ld_idx] = 1'b0;
    if (ld_slot) begin m_slot[ld_idx] = {ld_h1, ld_h0, ld_m1, ld_m0}; m_en[ld_idx] = ld_en; end
    if (m_state == 0) begin
      low = -1;
      for (int i = 3; i >= 0; i--) if (pn[i]) low = i;
      if (low >= 0) begin
        pn[low] = 1'b0; m_state = 1; m_act = low; m_ring = 0; m_cnt = 0;
      end
    end else if (m_state == 1) begin
      if (stop) m_state = 0;
`ifdef ALARM_SNOOZE_EN
      else if (snooze && m_cnt < 3) begin
        m_state = 2; m_cnt++; m_wake = (curmin + 5) % 1440;
      end
`endif
      else if (m_ring == 59) m_state = 0;
      else m_ring++;
    end else begin
      if (stop) m_state = 0;
      else if (curmin == m_wake && sec0) begin m_state = 1; m_ring = 0; end
    end
    m_pend = pn;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_checks++; if (obs !== 11'd0) begin n_fail++; $display("FAIL reset_hold: got %b want %b", obs, 11'd0); end
    @(negedge clk_1s);
    reset = 1'b0;
    tick();
    n_checks++; if (obs !== 11'd0) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs, 11'd0); end
  endtask

  task automatic test_basic();
    load(0, 7, 30, 1'b1);
    set_time(7, 29, 59); tick();
    want = {1'b0, 2'b00, 2'd0, 4'b0000, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL basic_before: got %b want %b", obs, want); end
    set_time(7, 30, 0); tick();
    want = {1'b1, 2'b01, 2'd0, 4'b0000, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL basic_ring: got %b want %b", obs, want); end
    set_time(7, 30, 1); stop = 1'b1; tick(); stop = 1'b0;
    want = {1'b0, 2'b00, 2'd0, 4'b0000, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL basic_stop: got %b want %b", obs, want); end
  endtask

  task automatic test_timeout();
    int highs;
    set_time(7, 30, 0); tick();
    highs = alarm ? 1 : 0;
    set_time(7, 30, 1);
    for (int i = 0; i < 70; i++) begin tick(); if (alarm) highs++; end
    n_checks++; if (highs != 60) begin n_fail++; $display("FAIL timeout_len: got %0d want %0d", highs, 60); end
    want = {1'b0, 2'b00, 2'd0, 4'b0000, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL timeout_idle: got %b want %b", obs, want); end
    clear_slots();
  endtask

  task automatic test_back_to_back();
    load(1, 6, 0, 1'b1); load(2, 6, 0, 1'b1);
    set_time(6, 0, 0); tick();
    want = {1'b1, 2'b01, 2'd1, 4'b0100, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL b2b_first: got %b want %b", obs, want); end
    set_time(6, 0, 1); stop = 1'b1; tick(); stop = 1'b0;
    want = {1'b0, 2'b00, 2'd1, 4'b0100, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL b2b_gap: got %b want %b", obs, want); end
    tick();
    want = {1'b1, 2'b01, 2'd2, 4'b0000, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL b2b_second: got %b want %b", obs, want); end
    stop = 1'b1; tick(); stop = 1'b0;
    clear_slots();
  endtask

  task automatic test_stop_priority_and_unload();
    load(3, 12, 0, 1'b1);
    set_time(12, 0, 0); tick();
    set_time(12, 0, 1); stop = 1'b1; snooze = 1'b1; tick(); stop = 1'b0; snooze = 1'b0;
    want = {1'b0, 2'b00, 2'd3, 4'b0000, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL stop_over_snooze: got %b want %b", obs, want); end
    load(0, 8, 0, 1'b1); load(1, 8, 0, 1'b1);
    set_time(8, 0, 0); tick();
    want = {1'b1, 2'b01, 2'd0, 4'b0010, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL unload_pend: got %b want %b", obs, want); end
    set_time(8, 0, 1); load(1, 8, 0, 1'b0);
    want = {1'b1, 2'b01, 2'd0, 4'b0000, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL unload_clear: got %b want %b", obs, want); end
    stop = 1'b1; tick(); stop = 1'b0; tick();
    want = {1'b0, 2'b00, 2'd0, 4'b0000, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL unload_never: got %b want %b", obs, want); end
    clear_slots();
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze();
    load(0, 23, 58, 1'b1);
    set_time(23, 58, 0); tick();
    set_time(23, 58, 1); tick(); tick();
    snooze = 1'b1; tick(); snooze = 1'b0;
    want = {1'b0, 2'b10, 2'd0, 4'b0000, 2'd1};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL snooze_enter: got %b want %b", obs, want); end
    set_time(0, 2, 59); tick();
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL snooze_wait: got %b want %b", obs, want); end
    set_time(0, 3, 0); tick();
    want = {1'b1, 2'b01, 2'd0, 4'b0000, 2'd1};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL snooze_wrap_wake: got %b want %b", obs, want); end
    for (int k = 2; k <= 3; k++) begin
      set_time(0, 3 + 5 * (k - 2), 1); snooze = 1'b1; tick(); snooze = 1'b0;
      set_time(0, 8 + 5 * (k - 2), 0); tick();
      want = {1'b1, 2'b01, 2'd0, 4'b0000, 2'(k)};
      n_checks++; if (obs !== want) begin n_fail++; $display("FAIL snooze_rewake%0d: got %b want %b", k, obs, want); end
    end
    set_time(0, 13, 1); snooze = 1'b1; tick(); snooze = 1'b0;
    want = {1'b1, 2'b01, 2'd0, 4'b0000, 2'd3};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL snooze_limit: got %b want %b", obs, want); end
    stop = 1'b1; tick(); stop = 1'b0;
    clear_slots();
  endtask
`else
  task automatic test_snooze();
    load(0, 23, 58, 1'b1);
    set_time(23, 58, 0); tick();
    set_time(23, 58, 1); snooze = 1'b1; tick(); snooze = 1'b0;
    want = {1'b1, 2'b01, 2'd0, 4'b0000, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL snooze_ignored: got %b want %b", obs, want); end
    stop = 1'b1; tick(); stop = 1'b0;
    clear_slots();
  endtask
`endif

  task automatic test_async_reset();
    load(2, 9, 15, 1'b1); load(3, 9, 15, 1'b1);
    set_time(9, 15, 0); tick();
    want = {1'b1, 2'b01, 2'd2, 4'b1000, 2'd0};
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL areset_pre: got %b want %b", obs, want); end
    set_time(9, 15, 1);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (obs !== 11'd0) begin n_fail++; $display("FAIL areset_now: got %b want %b", obs, 11'd0); end
    #2 reset = 1'b0;
    set_time(9, 15, 0); tick();
    n_checks++; if (obs !== 11'd0) begin n_fail++; $display("FAIL areset_disabled: got %b want %b", obs, 11'd0); end
  endtask

  task automatic test_random();
    int minute;
    reset = 1'b1; #2 reset = 1'b0;
    model_reset();
    minute = 0;
    for (int n = 0; n < 800; n++) begin
      ld_slot = ($urandom_range(0, 7) == 0);
      ld_idx  = 2'($urandom_range(0, 3));
      ld_h1   = 2'd0;
      ld_h0   = ($urandom_range(0, 9) == 0) ? 4'hA : 4'd6;
      ld_m1   = 4'd0;
      ld_m0   = 4'($urandom_range(0, 9));
      ld_en   = ($urandom_range(0, 3) != 0);
      stop    = ($urandom_range(0, 11) == 0);
      snooze  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) minute = $urandom_range(0, 14);
      set_time(6, minute, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 59));
      model_step();
      tick();
      want = {m_state == 1, 2'(m_state), 2'(m_act), m_pend, 2'(m_cnt)};
      n_checks++; if (obs !== want) begin n_fail++; $display("FAIL random_cycle%0d: got %b want %b", n, obs, want); end
    end
    ld_slot = 1'b0; stop = 1'b0; snooze = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ld_slot = 1'b0; ld_idx = 2'd0; ld_h1 = 2'd0; ld_h0 = 4'd0;
    ld_m1 = 4'd0; ld_m0 = 4'd0; ld_en = 1'b0; stop = 1'b0; snooze = 1'b0;
    set_time(12, 34, 56);
    test_reset();
    test_basic();
    test_timeout();
    test_back_to_back();
    test_stop_priority_and_unload();
    test_snooze();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
